// File: rtl/fmt_pkg.sv
// Shared types, pkglen_sel encodings and the length decoder for the fmt_packer formatter.
package fmt_pkg;

    typedef enum logic [1:0] {IDLE, FILL, REQ, SEND} fmt_state_e;

    localparam logic [2:0] LEN4  = 3'd0;
    localparam logic [2:0] LEN8  = 3'd1;
    localparam logic [2:0] LEN16 = 3'd2;
    localparam logic [2:0] LEN32 = 3'd3;

    // Selects above the largest legal shift, or lengths past the buffer, clamp to maxlen.
    function automatic int unsigned len_decode(input logic [2:0] sel, input int unsigned maxlen);
        int unsigned len;
        len = 32'd4 << sel;
        if (sel > 3'd5 || len > maxlen) begin
            len = maxlen;
        end
        return len;
    endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// Packet storage: one write port, one asynchronous read port, no reset on the array.
module fmt_pkt_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fmt_packer.sv
// Packet formatter: buffers one single-channel packet from the arbiter, requests the bus,
// then streams it out with start/end framing under sink back-pressure.
module fmt_packer
    import fmt_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned NCH    = 4,
    parameter int unsigned MAXLEN = 32,
    localparam int unsigned CHW   = $clog2(NCH),
    localparam int unsigned LW    = $clog2(MAXLEN) + 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [2:0]     pkglen_sel_i,
    input  logic           a2f_val_i,
    input  logic [CHW-1:0] a2f_id_i,
    input  logic [DW-1:0]  a2f_data_i,
    output logic           f2a_ack_o,
    output logic           fmt_id_req_o,
    input  logic           fmt_grant_i,
    input  logic           fmt_rdy_i,
    output logic           fmt_req_o,
    output logic [CHW-1:0] fmt_chid_o,
    output logic [LW-1:0]  fmt_length_o,
    output logic [DW-1:0]  fmt_data_o,
    output logic           fmt_start_o,
    output logic           fmt_end_o
);

    localparam int unsigned AW = $clog2(MAXLEN);

    fmt_state_e     state, state_next;
    logic [CHW-1:0] cur_ch;
    logic [LW-1:0]  cur_len, wr_cnt, rd_cnt, dec_len;
    logic           out_vld, buf_we, last_xfer, consume, done, load;
    logic [AW-1:0]  buf_waddr;
    logic [DW-1:0]  buf_rdata;

    assign dec_len   = LW'(len_decode(pkglen_sel_i, MAXLEN));
    assign last_xfer = (state == FILL) && buf_we && (wr_cnt == cur_len - LW'(1));
    assign consume   = out_vld && fmt_rdy_i;
    assign done      = consume && fmt_end_o;
    // The first SEND cycle preloads word 0; afterwards a word is fetched only as one is consumed.
    assign load      = (state == SEND) && (!out_vld || (consume && !fmt_end_o));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (a2f_val_i) state_next = FILL;
            FILL:    if (last_xfer) state_next = REQ;
            REQ:     if (fmt_grant_i) state_next = SEND;
            SEND:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        f2a_ack_o    = 1'b0;
        fmt_id_req_o = 1'b0;
        buf_waddr    = wr_cnt[AW-1:0];
        if (rstn_i) begin
            case (state)
                IDLE: begin
                    fmt_id_req_o = 1'b1;
                    f2a_ack_o    = a2f_val_i;
                    buf_waddr    = '0;
                end
                FILL:    f2a_ack_o = (a2f_id_i == cur_ch);
                default: f2a_ack_o = 1'b0;
            endcase
        end
        buf_we = a2f_val_i && f2a_ack_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cur_ch       <= '0;
            cur_len      <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            out_vld      <= 1'b0;
            fmt_req_o    <= 1'b0;
            fmt_chid_o   <= '0;
            fmt_length_o <= '0;
            fmt_data_o   <= '0;
            fmt_start_o  <= 1'b0;
            fmt_end_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a2f_val_i) begin
                        cur_ch  <= a2f_id_i;
                        cur_len <= dec_len;
                        wr_cnt  <= LW'(1);
                        rd_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (buf_we) begin
                        wr_cnt <= wr_cnt + LW'(1);
                    end
                    if (last_xfer) begin
                        fmt_req_o    <= 1'b1;
                        fmt_chid_o   <= cur_ch;
                        fmt_length_o <= cur_len;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        fmt_req_o <= 1'b0;
                        rd_cnt    <= '0;
                    end
                end
                SEND: begin
                    if (done) begin
                        out_vld      <= 1'b0;
                        fmt_chid_o   <= '0;
                        fmt_length_o <= '0;
                        fmt_data_o   <= '0;
                        fmt_start_o  <= 1'b0;
                        fmt_end_o    <= 1'b0;
                    end else if (load) begin
                        out_vld     <= 1'b1;
                        fmt_data_o  <= buf_rdata;
                        fmt_start_o <= (rd_cnt == '0);
                        fmt_end_o   <= (rd_cnt == cur_len - LW'(1));
                        rd_cnt      <= rd_cnt + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    fmt_pkt_buf #(
        .DW    (DW),
        .DEPTH (MAXLEN)
    ) u_buf (
        .clk   (clk_i),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (a2f_data_i),
        .raddr (rd_cnt[AW-1:0]),
        .rdata (buf_rdata)
    );

endmodule

// File: tb/tb_fmt_packer.sv
// Directed bench for fmt_packer: fill, request, send, back-pressure, mid-packet reset.
module tb_fmt_packer;
    import fmt_pkg::*;

    logic        clk;
    logic        rstn;
    logic [2:0]  pkglen_sel;
    logic        a2f_val;
    logic [1:0]  a2f_id;
    logic [31:0] a2f_data;
    logic        f2a_ack;
    logic        fmt_id_req;
    logic        fmt_grant;
    logic        fmt_rdy;
    logic        fmt_req;
    logic [1:0]  fmt_chid;
    logic [5:0]  fmt_length;
    logic [31:0] fmt_data;
    logic        fmt_start;
    logic        fmt_end;

    int passed = 0;
    int total  = 0;

    logic [31:0] got_data [64];
    logic        got_start [64];
    logic        got_end [64];
    logic [31:0] hold_data [8];
    logic        hold_start [8];
    logic        hold_end [8];

    fmt_packer #(
        .DW     (32),
        .NCH    (4),
        .MAXLEN (32)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .pkglen_sel_i (pkglen_sel),
        .a2f_val_i    (a2f_val),
        .a2f_id_i     (a2f_id),
        .a2f_data_i   (a2f_data),
        .f2a_ack_o    (f2a_ack),
        .fmt_id_req_o (fmt_id_req),
        .fmt_grant_i  (fmt_grant),
        .fmt_rdy_i    (fmt_rdy),
        .fmt_req_o    (fmt_req),
        .fmt_chid_o   (fmt_chid),
        .fmt_length_o (fmt_length),
        .fmt_data_o   (fmt_data),
        .fmt_start_o  (fmt_start),
        .fmt_end_o    (fmt_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word at the falling edge; report the combinational ack seen for it.
    task automatic put(input logic [1:0] id, input logic [31:0] d, output logic ack);
        @(negedge clk);
        a2f_val  = 1'b1;
        a2f_id   = id;
        a2f_data = d;
        #1;
        ack = f2a_ack;
    endtask

    task automatic end_fill();
        @(negedge clk);
        a2f_val = 1'b0;
    endtask

    task automatic fill(input logic [1:0] id, input logic [31:0] base, input int n,
                        output int acks);
        logic ack;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            put(id, base + 32'(i), ack);
            if (ack) acks++;
        end
        end_fill();
    endtask

    // Grant the bus and record every presented word until the end word is consumed.
    task automatic drain(input int stall_at, input int stall_len,
                         output int nwords, output int ncyc, output bit to);
        int stalls;
        stalls = 0;
        nwords = 0;
        ncyc   = 0;
        to     = 1'b1;
        @(negedge clk);
        fmt_grant = 1'b1;
        fmt_rdy   = 1'b1;
        @(negedge clk);
        fmt_grant = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ncyc++;
            if (nwords == stall_at && stalls < stall_len) begin
                fmt_rdy = 1'b0;
                hold_data[stalls]  = fmt_data;
                hold_start[stalls] = fmt_start;
                hold_end[stalls]   = fmt_end;
                stalls++;
            end else begin
                fmt_rdy = 1'b1;
                if (nwords >= 64) break;
                got_data[nwords]  = fmt_data;
                got_start[nwords] = fmt_start;
                got_end[nwords]   = fmt_end;
                nwords++;
                if (fmt_end) begin
                    to = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; a2f_val = 1'b1; a2f_id = 2'd0;
        @(negedge clk);
        total++; if (f2a_ack !== 1'b0) $display("FAIL rst_ack got %b want 0", f2a_ack); else passed++;
        total++; if (fmt_id_req !== 1'b0) $display("FAIL rst_idreq got %b want 0", fmt_id_req); else passed++;
        total++;
        if ({fmt_req, fmt_start, fmt_end, fmt_chid, fmt_length, fmt_data} !== 42'd0)
            $display("FAIL rst_outs got %h want 0", {fmt_req, fmt_start, fmt_end, fmt_chid, fmt_length, fmt_data});
        else passed++;
        rstn = 1'b1; a2f_val = 1'b0;
        #1;
        total++; if (fmt_id_req !== 1'b1) $display("FAIL rst_idle_idreq got %b want 1", fmt_id_req); else passed++;
    endtask

    task automatic test_basic();
        logic ack;
        int acks, nw, nc;
        bit to;
        acks = 0;
        pkglen_sel = LEN4;
        put(2'd1, 32'hA0, ack); if (ack) acks++;
        put(2'd1, 32'hA1, ack); if (ack) acks++;
        fmt_grant = 1'b1;
        put(2'd1, 32'hA2, ack); if (ack) acks++;
        fmt_grant = 1'b0;
        put(2'd1, 32'hA3, ack); if (ack) acks++;
        put(2'd1, 32'hA4, ack);
        total++; if (ack !== 1'b0) $display("FAIL t1_full_ack got %b want 0", ack); else passed++;
        a2f_val = 1'b0;
        total++; if (acks != 4) $display("FAIL t1_acks got %0d want 4", acks); else passed++;
        total++; if (fmt_req !== 1'b1) $display("FAIL t1_req got %b want 1", fmt_req); else passed++;
        total++; if (fmt_chid !== 2'd1) $display("FAIL t1_chid got %0d want 1", fmt_chid); else passed++;
        total++; if (fmt_length !== 6'd4) $display("FAIL t1_len got %0d want 4", fmt_length); else passed++;
        total++; if (fmt_id_req !== 1'b0) $display("FAIL t1_idreq got %b want 0", fmt_id_req); else passed++;
        @(negedge clk); @(negedge clk);
        total++;
        if (fmt_req !== 1'b1 || fmt_start !== 1'b0)
            $display("FAIL t1_early_grant got req=%b start=%b want req=1 start=0", fmt_req, fmt_start);
        else passed++;
        drain(-1, 0, nw, nc, to);
        total++; if (to) $display("FAIL t1_timeout got no end want end"); else passed++;
        total++;
        if (got_data[0] !== 32'hA0 || got_start[0] !== 1'b1 || got_end[0] !== 1'b0)
            $display("FAIL t1_first got %h s=%b e=%b want a0 s=1 e=0", got_data[0], got_start[0], got_end[0]);
        else passed++;
        total++;
        if (got_data[3] !== 32'hA3 || got_start[3] !== 1'b0 || got_end[3] !== 1'b1)
            $display("FAIL t1_last got %h s=%b e=%b want a3 s=0 e=1", got_data[3], got_start[3], got_end[3]);
        else passed++;
        total++; if (nc != 4) $display("FAIL t1_cycles got %0d want 4", nc); else passed++;
        total++;
        if (fmt_data !== 32'd0 || fmt_end !== 1'b0 || fmt_req !== 1'b0 || fmt_id_req !== 1'b1)
            $display("FAIL t1_after got d=%h e=%b r=%b idreq=%b want 0 0 0 1", fmt_data, fmt_end, fmt_req, fmt_id_req);
        else passed++;
    endtask

    task automatic test_clamp();
        int acks, nw, nc;
        bit to;
        pkglen_sel = 3'd5;
        fill(2'd3, 32'h100, 32, acks);
        total++; if (acks != 32) $display("FAIL t2_acks got %0d want 32", acks); else passed++;
        total++; if (fmt_length !== 6'd32) $display("FAIL t2_len got %0d want 32", fmt_length); else passed++;
        drain(-1, 0, nw, nc, to);
        total++; if (to || nw != 32) $display("FAIL t2_words got %0d want 32", nw); else passed++;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (got_data[i] !== 32'h100 + 32'(i) || got_end[i] !== (i == 31) || got_start[i] !== (i == 0))
                $display("FAIL t2_word%0d got %h s=%b e=%b want %h", i, got_data[i], got_start[i], got_end[i], 32'h100 + 32'(i));
            else passed++;
        end
    endtask

    task automatic test_id_filter();
        logic ack;
        int acks, nw, nc;
        bit to;
        acks = 0;
        pkglen_sel = LEN4;
        put(2'd0, 32'hC0, ack); if (ack) acks++;
        put(2'd0, 32'hC1, ack); if (ack) acks++;
        put(2'd2, 32'hEE, ack);
        total++; if (ack !== 1'b0) $display("FAIL t3_foreign_ack got %b want 0", ack); else passed++;
        put(2'd2, 32'hEE, ack);
        total++; if (ack !== 1'b0) $display("FAIL t3_foreign_ack2 got %b want 0", ack); else passed++;
        put(2'd0, 32'hC2, ack); if (ack) acks++;
        put(2'd0, 32'hC3, ack); if (ack) acks++;
        end_fill();
        total++; if (acks != 4) $display("FAIL t3_acks got %0d want 4", acks); else passed++;
        total++;
        if (fmt_req !== 1'b1 || fmt_chid !== 2'd0)
            $display("FAIL t3_req got req=%b ch=%0d want 1 0", fmt_req, fmt_chid);
        else passed++;
        drain(-1, 0, nw, nc, to);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== 32'hC0 + 32'(i))
                $display("FAIL t3_word%0d got %h want %h", i, got_data[i], 32'hC0 + 32'(i));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int acks, nw, nc;
        bit to;
        pkglen_sel = LEN8;
        fill(2'd2, 32'h200, 8, acks);
        drain(2, 3, nw, nc, to);
        total++; if (to || nw != 8) $display("FAIL t4_words got %0d want 8", nw); else passed++;
        total++; if (nc != 11) $display("FAIL t4_cycles got %0d want 11", nc); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hold_data[i] !== 32'h202 || hold_start[i] !== 1'b0 || hold_end[i] !== 1'b0)
                $display("FAIL t4_hold%0d got %h s=%b e=%b want 202 0 0", i, hold_data[i], hold_start[i], hold_end[i]);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_data[i] !== 32'h200 + 32'(i) || got_end[i] !== (i == 7))
                $display("FAIL t4_word%0d got %h e=%b want %h", i, got_data[i], got_end[i], 32'h200 + 32'(i));
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int acks, nw, nc;
        bit to;
        pkglen_sel = LEN8;
        fill(2'd1, 32'h300, 8, acks);
        @(negedge clk); fmt_grant = 1'b1; fmt_rdy = 1'b1;
        @(negedge clk); fmt_grant = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        total++; if (fmt_data !== 32'h304) $display("FAIL t5_word5 got %h want 304", fmt_data); else passed++;
        rstn = 1'b0; a2f_val = 1'b1; a2f_id = 2'd1;
        #1;
        total++;
        if (f2a_ack !== 1'b0 || fmt_id_req !== 1'b0)
            $display("FAIL t5_rst_comb got ack=%b idreq=%b want 0 0", f2a_ack, fmt_id_req);
        else passed++;
        @(negedge clk);
        total++;
        if ({fmt_req, fmt_start, fmt_end, fmt_chid, fmt_length, fmt_data} !== 42'd0)
            $display("FAIL t5_rst_outs got %h want 0", {fmt_req, fmt_start, fmt_end, fmt_chid, fmt_length, fmt_data});
        else passed++;
        rstn = 1'b1; a2f_val = 1'b0;
        @(negedge clk);
        total++; if (fmt_id_req !== 1'b1) $display("FAIL t5_idreq got %b want 1", fmt_id_req); else passed++;
        pkglen_sel = LEN4;
        fill(2'd3, 32'h400, 4, acks);
        total++;
        if (fmt_chid !== 2'd3 || fmt_length !== 6'd4)
            $display("FAIL t5_next_hdr got ch=%0d len=%0d want 3 4", fmt_chid, fmt_length);
        else passed++;
        drain(-1, 0, nw, nc, to);
        total++;
        if (got_data[0] !== 32'h400 || got_start[0] !== 1'b1)
            $display("FAIL t5_next_first got %h s=%b want 400 1", got_data[0], got_start[0]);
        else passed++;
        total++;
        if (to || nc != 4 || got_data[3] !== 32'h403 || got_end[3] !== 1'b1)
            $display("FAIL t5_next_last got %h e=%b cyc=%0d want 403 1 4", got_data[3], got_end[3], nc);
        else passed++;
    endtask

    task automatic test_len_change();
        logic ack;
        int acks, nw, nc;
        bit to;
        acks = 0;
        pkglen_sel = LEN8;
        put(2'd0, 32'h500, ack); if (ack) acks++;
        put(2'd0, 32'h501, ack); if (ack) acks++;
        pkglen_sel = LEN16;
        for (int i = 2; i < 8; i++) begin
            put(2'd0, 32'h500 + 32'(i), ack); if (ack) acks++;
        end
        end_fill();
        total++; if (acks != 8) $display("FAIL t6_acks got %0d want 8", acks); else passed++;
        total++; if (fmt_length !== 6'd8) $display("FAIL t6_len got %0d want 8", fmt_length); else passed++;
        drain(-1, 0, nw, nc, to);
        total++; if (to || nw != 8) $display("FAIL t6_words got %0d want 8", nw); else passed++;
        fill(2'd1, 32'h600, 16, acks);
        total++; if (acks != 16) $display("FAIL t6_next_acks got %0d want 16", acks); else passed++;
        total++; if (fmt_length !== 6'd16) $display("FAIL t6_next_len got %0d want 16", fmt_length); else passed++;
        drain(-1, 0, nw, nc, to);
        total++;
        if (to || nw != 16 || got_data[15] !== 32'h60F || got_end[15] !== 1'b1)
            $display("FAIL t6_next_last got n=%0d %h e=%b want 16 60f 1", nw, got_data[15], got_end[15]);
        else passed++;
    endtask

    initial begin
        rstn       = 1'b0;
        pkglen_sel = LEN4;
        a2f_val    = 1'b0;
        a2f_id     = 2'd0;
        a2f_data   = 32'd0;
        fmt_grant  = 1'b0;
        fmt_rdy    = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_id_filter();
        test_backpressure();
        test_reset_mid();
        test_len_change();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fmt_packer.md
Name: fmt_packer

Overview:
- Parametrised successor to the MCDF packet formatter.
- Takes words from the channel arbiter over a valid/ack handshake and buffers one packet of a programmable length for a single channel.
- Requests the outside bus, and once granted streams the packet with start/end framing.
- Sits between the arbiter and the MCDF output port; generalises data width, channel count and maximum packet length, and adds proper channel latching and output back-pressure.

Parameters:
DW, 32, data word width in bits
NCH, 4, number of source channels (>=2)
MAXLEN, 32, maximum packet length in words; power of two, >=4; also the buffer depth
CHW, $clog2(NCH), channel id width (derived, not overridable)
LW, $clog2(MAXLEN)+1, packet length field width (derived)

Ports:
clk_i  input  1  clock
rstn_i  input  1  synchronous active-low reset
pkglen_sel_i  input  3  packet length select, sampled at packet start
a2f_val_i  input  1  arbiter word valid
a2f_id_i  input  CHW  channel id of the current arbiter word
a2f_data_i  input  DW  arbiter data word
f2a_ack_o  output  1  formatter accepts the word this cycle
fmt_id_req_o  output  1  formatter is idle and requests a new channel from the arbiter
fmt_grant_i  input  1  outside bus grant
fmt_rdy_i  input  1  outside sink ready; data advances only when high
fmt_req_o  output  1  packet ready, bus requested
fmt_chid_o  output  CHW  channel id of the packet being sent
fmt_length_o  output  LW  packet length in words
fmt_data_o  output  DW  packet data word
fmt_start_o  output  1  first word of packet
fmt_end_o  output  1  last word of packet

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rstn_i.
- Reset values: all registered outputs are 0, the state is IDLE, and all counters are 0.
- f2a_ack_o and fmt_id_req_o are combinational and forced to 0 while rstn_i=0.
- Length decode: len = 4 << pkglen_sel_i. If len > MAXLEN, or pkglen_sel_i > 5, then len = MAXLEN.
- IDLE:
  - fmt_id_req_o=1.
  - On the first cycle with a2f_val_i=1, latch cur_ch=a2f_id_i and cur_len=decoded len, store that word at buffer[0] (f2a_ack_o=1 in the same cycle), set wr_cnt=1, and go to FILL.
- FILL:
  - f2a_ack_o = a2f_val_i-independent and equal to (a2f_id_i==cur_ch).
  - A transfer is a cycle with a2f_val_i && f2a_ack_o; each transfer writes buffer[wr_cnt] and increments wr_cnt.
  - A word whose id differs from cur_ch is not acked; the arbiter holds it.
  - When the transfer brings wr_cnt to cur_len, go to REQ the next cycle.
  - Changes on pkglen_sel_i after packet start are ignored.
- REQ:
  - fmt_req_o=1, fmt_chid_o=cur_ch, fmt_length_o=cur_len, f2a_ack_o=0.
  - When fmt_grant_i=1, drop fmt_req_o the next cycle and go to SEND, with rd_cnt=0.
- SEND:
  - fmt_data_o=buffer[rd_cnt], registered; fmt_start_o=(rd_cnt==0); fmt_end_o=(rd_cnt==cur_len-1).
  - A word is consumed in a cycle where fmt_rdy_i=1. While fmt_rdy_i=0, data, start and end hold.
  - After the end word is consumed, clear the outputs to 0 and return to IDLE. fmt_id_req_o=1 from the following cycle.
- Latency:
  - Grant sampled at edge N gives the start word valid after edge N+1.
  - A full packet occupies cur_len cycles with fmt_rdy_i held at 1.
- Boundary conditions:
  - Grant arriving before REQ is ignored.
  - Grant held high across packets is honoured only in REQ.
  - a2f_val_i=1 in the last FILL cycle is accepted only if the buffer is not yet full; it is never acked once wr_cnt==cur_len.
  - wr_cnt and rd_cnt never wrap; both reset to 0 at packet start.
  - fmt_data_o is 0 outside SEND.
  - rstn_i=0 mid-packet discards the buffered packet with no end word emitted; all outputs are 0 on the next edge.

Decomposition:
- Shared package fmt_pkg holds:
  - state enum {IDLE, FILL, REQ, SEND};
  - function len_decode(sel, MAXLEN);
  - constants for the pkglen_sel encodings (LEN4=0 … LEN32=3).
- One sub-module, fmt_pkt_buf: MAXLEN x DW single-write single-read register buffer with write enable/address and read address, no reset on the storage array.

Test Plan:
1. Reset, then pkglen_sel_i=0 and ch1 sends 4 words 0xA0..0xA3 back-to-back. Required: req after the 4th ack; grant gives start with 0xA0, end with 0xA3, fmt_length_o=4, fmt_chid_o=1.
2. MAXLEN=32, pkglen_sel_i=5. Required: length clamps to 32; 32 words accepted and sent in order; fmt_end_o exactly on the 32nd word.
3. During FILL for ch0, present a word with id=2. Required: f2a_ack_o=0 and it is not stored; packet contents are ch0 only.
4. In SEND, drop fmt_rdy_i for 3 cycles at word 2. Required: data, start and end hold; no word is lost or duplicated; total send is len+3 cycles.
5. Assert rstn_i=0 for 1 cycle mid-SEND at word 5 of 8. Required: all outputs 0 after the edge, fmt_id_req_o=1 after release, and the next packet starts clean at buffer[0].
6. Change pkglen_sel_i from 1 to 2 during FILL. Required: the packet remains 8 words; the next packet is 16 words.
